rx_payload_packer: RTL and testbench

//  Downstream stage of the receive MAC parser. Consumes its 8-bit payload stream
//  (tvalid/tfirst/tlast + 16-bit data length) and packs bytes big-endian into
//  32-bit words with byte keep. Words are buffered in a FIFO and presented on a

---
 rtl/rx_payload_packer.sv | 242 ++++++++++++++++++++++++
 tb/tb_rx_payload_packer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx_payload_packer.sv
// Packs the MAC parser's byte payload stream big-endian into 32-bit words behind a
// first-word-fall-through FIFO, admitting or dropping whole frames. Optional counters: RX_PACK_STATS_EN.
module rx_payload_packer #(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_tdata,
    input  logic              in_tvalid,
    input  logic              in_tfirst,
    input  logic              in_tlast,
    input  logic [15:0]       in_len,
    output logic [31:0]       out_tdata,
    output logic [3:0]        out_tkeep,
    output logic              out_tvalid,
    output logic              out_tlast,
    input  logic              out_tready,
    output logic [ADDR_W:0]   fifo_count,
    output logic              len_err,
    output logic              frame_drop,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       drop_cnt
);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PACK = 2'd1, ST_DROP = 2'd2} state_t;

    localparam logic [16:0]       DEPTH_L = 17'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_r, state_s;
    logic [31:0]       word_r, word_s, word_fill_s, lane_word_s;
    logic [3:0]        keep_r, keep_s, keep_fill_s;
    logic [1:0]        lane_r, lane_s;
    logic [15:0]       byte_cnt_r, byte_cnt_s, len_r, len_s;
    logic [15:0]       cnt_base_s, cnt_new_s, len_cur_s;
    logic              push_r, push_s, push_last_r, push_last_s;
    logic [31:0]       push_data_r, push_data_s;
    logic [3:0]        push_keep_r, push_keep_s;
    logic              len_err_r, len_err_s, frame_drop_r, frame_drop_s;
    logic              take_s, end_len_s, end_s, admit_s;
    logic [16:0]       need_s, free_s;
    logic [36:0]       mem_r [FIFO_DEPTH];
    logic [36:0]       rd_word_s;
    logic [ADDR_W-1:0] wr_ptr_r, rd_ptr_r;
    logic [ADDR_W:0]   fifo_count_r;
    logic              pop_s;

    // Admission: a pending push already owns a slot even though fifo_count has not seen it yet.
    always_comb begin
        need_s     = ({1'b0, in_len} + 17'd3) >> 2;
        free_s     = DEPTH_L - {{(16-ADDR_W){1'b0}}, fifo_count_r} - {16'd0, push_r};
        admit_s    = (in_len != 16'd0) && (need_s <= free_s);
        cnt_base_s = (state_r == ST_IDLE) ? 16'd0 : byte_cnt_r;
        len_cur_s  = (state_r == ST_IDLE) ? in_len : len_r;
        cnt_new_s  = cnt_base_s + 16'd1;
        end_len_s  = (cnt_new_s == len_cur_s);
        end_s      = end_len_s || in_tlast;
        case (lane_r)
            2'd0:    lane_word_s = {in_tdata, 24'd0};
            2'd1:    lane_word_s = {8'd0, in_tdata, 16'd0};
            2'd2:    lane_word_s = {16'd0, in_tdata, 8'd0};
            default: lane_word_s = {24'd0, in_tdata};
        endcase
        word_fill_s = word_r | lane_word_s;
        keep_fill_s = keep_r | (4'b1000 >> lane_r);
    end

    // Frame FSM and lane packer next-state.
    always_comb begin
        state_s      = state_r;
        word_s       = word_r;
        keep_s       = keep_r;
        lane_s       = lane_r;
        byte_cnt_s   = byte_cnt_r;
        len_s        = len_r;
        push_s       = 1'b0;
        push_data_s  = word_r;
        push_keep_s  = keep_r;
        push_last_s  = 1'b0;
        len_err_s    = 1'b0;
        frame_drop_s = 1'b0;
        take_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_tvalid && in_tfirst) begin
                    if (admit_s) begin
                        len_s  = in_len;
                        take_s = 1'b1;
                    end else begin
                        frame_drop_s = 1'b1;
                        len_err_s    = (in_len == 16'd0);
                        state_s      = in_tlast ? ST_IDLE : ST_DROP;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PACK: begin
                if (in_tvalid && in_tfirst) begin
                    // An empty partial word has nothing left to flush.
                    push_s      = (lane_r != 2'd0);
                    push_last_s = 1'b1;
                    len_err_s   = 1'b1;
                    word_s      = 32'd0;
                    keep_s      = 4'd0;
                    lane_s      = 2'd0;
                    state_s     = ST_DROP;
                end else begin
                    take_s = in_tvalid;
                end
            end
            ST_DROP: begin
                if (in_tvalid && in_tlast) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DROP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
        if (take_s) begin
            byte_cnt_s = cnt_new_s;
            if (end_s || (lane_r == 2'd3)) begin
                push_s      = 1'b1;
                push_data_s = word_fill_s;
                push_keep_s = keep_fill_s;
                push_last_s = end_s;
                word_s      = 32'd0;
                keep_s      = 4'd0;
                lane_s      = 2'd0;
            end else begin
                word_s = word_fill_s;
                keep_s = keep_fill_s;
                lane_s = lane_r + 2'd1;
            end
            if (end_s) begin
                len_err_s = !(end_len_s && in_tlast);
                state_s   = in_tlast ? ST_IDLE : ST_DROP;
            end else begin
                state_s = ST_PACK;
            end
        end else begin
            byte_cnt_s = byte_cnt_s;
        end
    end

    // Packer, push stage and pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            word_r       <= 32'd0;
            keep_r       <= 4'd0;
            lane_r       <= 2'd0;
            byte_cnt_r   <= 16'd0;
            len_r        <= 16'd0;
            push_r       <= 1'b0;
            push_data_r  <= 32'd0;
            push_keep_r  <= 4'd0;
            push_last_r  <= 1'b0;
            len_err_r    <= 1'b0;
            frame_drop_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            word_r       <= word_s;
            keep_r       <= keep_s;
            lane_r       <= lane_s;
            byte_cnt_r   <= byte_cnt_s;
            len_r        <= len_s;
            push_r       <= push_s;
            push_data_r  <= push_data_s;
            push_keep_r  <= push_keep_s;
            push_last_r  <= push_last_s;
            len_err_r    <= len_err_s;
            frame_drop_r <= frame_drop_s;
        end
    end

    // FIFO storage; contents are qualified by fifo_count so need no reset.
    always_ff @(posedge clk) begin
        if (push_r) begin
            mem_r[wr_ptr_r] <= {push_data_r, push_keep_r, push_last_r};
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    assign pop_s = out_tvalid && out_tready;

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r     <= {ADDR_W{1'b0}};
            rd_ptr_r     <= {ADDR_W{1'b0}};
            fifo_count_r <= {(ADDR_W+1){1'b0}};
        end else begin
            if (push_r) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            else        wr_ptr_r <= wr_ptr_r;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            else        rd_ptr_r <= rd_ptr_r;
            case ({push_r, pop_s})
                2'b10:   fifo_count_r <= fifo_count_r + {{ADDR_W{1'b0}}, 1'b1};
                2'b01:   fifo_count_r <= fifo_count_r - {{ADDR_W{1'b0}}, 1'b1};
                default: fifo_count_r <= fifo_count_r;
            endcase
        end
    end

    assign rd_word_s  = mem_r[rd_ptr_r];
    assign out_tvalid = (fifo_count_r != {(ADDR_W+1){1'b0}});
    assign out_tdata  = out_tvalid ? rd_word_s[36:5] : 32'd0;
    assign out_tkeep  = out_tvalid ? rd_word_s[4:1]  : 4'd0;
    assign out_tlast  = out_tvalid ? rd_word_s[0]    : 1'b0;
    assign fifo_count = fifo_count_r;
    assign len_err    = len_err_r;
    assign frame_drop = frame_drop_r;

`ifdef RX_PACK_STATS_EN
    logic [15:0] frame_cnt_r, drop_cnt_r;
    logic        admit_evt_s;
    assign admit_evt_s = (state_r == ST_IDLE) && in_tvalid && in_tfirst && admit_s;

    // Frame statistics, free-running 16-bit wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_r <= 16'd0;
            drop_cnt_r  <= 16'd0;
        end else begin
            if (admit_evt_s)  frame_cnt_r <= frame_cnt_r + 16'd1;
            else              frame_cnt_r <= frame_cnt_r;
            if (frame_drop_s) drop_cnt_r  <= drop_cnt_r + 16'd1;
            else              drop_cnt_r  <= drop_cnt_r;
        end
    end
    assign frame_cnt = frame_cnt_r;
    assign drop_cnt  = drop_cnt_r;
`else
    assign frame_cnt = 16'd0;
    assign drop_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_rx_payload_packer.sv
// Self-checking bench for rx_payload_packer: vector table of single frames plus
// hand-written backpressure, latency, mid-frame tfirst and reset sequences.
module tb_rx_payload_packer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_tdata = 8'd0;
    logic        in_tvalid = 1'b0, in_tfirst = 1'b0, in_tlast = 1'b0;
    logic [15:0] in_len = 16'd0;
    logic [31:0] out_tdata;
    logic [3:0]  out_tkeep;
    logic        out_tvalid, out_tlast;
    logic        out_tready = 1'b1;
    logic [4:0]  fifo_count;
    logic        len_err, frame_drop;
    logic [15:0] frame_cnt, drop_cnt;

    rx_payload_packer #(.FIFO_DEPTH(16), .ADDR_W(4)) dut (
        .clk(clk), .reset(reset),
        .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tfirst(in_tfirst),
        .in_tlast(in_tlast), .in_len(in_len),
        .out_tdata(out_tdata), .out_tkeep(out_tkeep), .out_tvalid(out_tvalid),
        .out_tlast(out_tlast), .out_tready(out_tready), .fifo_count(fifo_count),
        .len_err(len_err), .frame_drop(frame_drop),
        .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int err_seen = 0;
    int drop_seen = 0;
    int drops_total = 0;
    logic [31:0] q_data[$];
    logic [3:0]  q_keep[$];
    logic        q_last[$];

    // Record accepted words and error pulses away from the active edge.
    always @(negedge clk) begin
        if (out_tvalid && out_tready) begin
            q_data.push_back(out_tdata);
            q_keep.push_back(out_tkeep);
            q_last.push_back(out_tlast);
        end
        if (len_err) err_seen++;
        if (frame_drop) begin
            drop_seen++;
            drops_total++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] b, input logic f, input logic l, input logic [15:0] len);
        in_tdata = b; in_tvalid = 1'b1; in_tfirst = f; in_tlast = l; in_len = len;
        @(posedge clk); #1;
        in_tvalid = 1'b0; in_tfirst = 1'b0; in_tlast = 1'b0;
    endtask

    task automatic idle(input int n);
        in_tvalid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clear_mon();
        q_data.delete(); q_keep.delete(); q_last.delete();
        err_seen = 0; drop_seen = 0;
    endtask

    typedef struct packed {
        logic [15:0]      len;
        logic [7:0]       nbytes;
        logic [7:0]       first;
        logic [7:0]       step;
        logic [7:0]       tlast_at;
        logic [7:0]       nwords;
        logic [1:0][31:0] d;
        logic [1:0][3:0]  k;
        logic [1:0]       l;
        logic [7:0]       errs;
        logic [7:0]       drops;
    } vec_t;

    vec_t vecs[8];

    function automatic vec_t mk(input logic [15:0] len, input logic [7:0] nb, input logic [7:0] first,
                                input logic [7:0] step, input logic [7:0] tl, input logic [7:0] nw,
                                input logic [31:0] d0, input logic [3:0] k0, input logic l0,
                                input logic [31:0] d1, input logic [3:0] k1, input logic l1,
                                input logic [7:0] errs, input logic [7:0] drops);
        vec_t v;
        v.len = len; v.nbytes = nb; v.first = first; v.step = step; v.tlast_at = tl; v.nwords = nw;
        v.d[0] = d0; v.k[0] = k0; v.l[0] = l0; v.d[1] = d1; v.k[1] = k1; v.l[1] = l1;
        v.errs = errs; v.drops = drops;
        return v;
    endfunction

    initial begin
        vecs[0] = mk(16'd8, 8'd8, 8'h01, 8'h01, 8'd7, 8'd2, 32'h01020304, 4'hF, 1'b0, 32'h05060708, 4'hF, 1'b1, 8'd0, 8'd0);
        vecs[1] = mk(16'd5, 8'd5, 8'hA1, 8'h01, 8'd4, 8'd2, 32'hA1A2A3A4, 4'hF, 1'b0, 32'hA5000000, 4'h8, 1'b1, 8'd0, 8'd0);
        vecs[2] = mk(16'd6, 8'd9, 8'h01, 8'h01, 8'd8, 8'd2, 32'h01020304, 4'hF, 1'b0, 32'h05060000, 4'hC, 1'b1, 8'd1, 8'd0);
        vecs[3] = mk(16'd8, 8'd3, 8'h11, 8'h11, 8'd2, 8'd1, 32'h11223300, 4'hE, 1'b1, 32'h0, 4'h0, 1'b0, 8'd1, 8'd0);
        vecs[4] = mk(16'd1, 8'd1, 8'h5A, 8'h01, 8'd0, 8'd1, 32'h5A000000, 4'h8, 1'b1, 32'h0, 4'h0, 1'b0, 8'd0, 8'd0);
        vecs[5] = mk(16'd4, 8'd5, 8'h01, 8'h01, 8'd4, 8'd1, 32'h01020304, 4'hF, 1'b1, 32'h0, 4'h0, 1'b0, 8'd1, 8'd0);
        vecs[6] = mk(16'd0, 8'd2, 8'h40, 8'h01, 8'd1, 8'd0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b0, 8'd1, 8'd1);
        vecs[7] = mk(16'd2, 8'd1, 8'h77, 8'h01, 8'd0, 8'd1, 32'h77000000, 4'h8, 1'b1, 32'h0, 4'h0, 1'b0, 8'd1, 8'd0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_tvalid", {31'd0, out_tvalid}, 32'd0);
        check("rst_tdata", out_tdata, 32'd0);
        check("rst_count", {27'd0, fifo_count}, 32'd0);
        check("rst_pulses", {30'd0, len_err, frame_drop}, 32'd0);
        reset = 1'b0;
        idle(2);

        // Table-driven single frames
        for (int v = 0; v < 8; v++) begin
            clear_mon();
            for (int i = 0; i < int'(vecs[v].nbytes); i++) begin
                logic [7:0] b;
                b = vecs[v].first + 8'(i) * vecs[v].step;
                drive(b, i == 0, i == int'(vecs[v].tlast_at), vecs[v].len);
            end
            idle(8);
            check($sformatf("v%0d_nwords", v), q_data.size(), {24'd0, vecs[v].nwords});
            for (int w = 0; w < int'(vecs[v].nwords); w++) begin
                check($sformatf("v%0d_w%0d_data", v, w), q_data[w], vecs[v].d[w]);
                check($sformatf("v%0d_w%0d_keep", v, w), {28'd0, q_keep[w]}, {28'd0, vecs[v].k[w]});
                check($sformatf("v%0d_w%0d_last", v, w), {31'd0, q_last[w]}, {31'd0, vecs[v].l[w]});
            end
            check($sformatf("v%0d_len_err", v), err_seen, {24'd0, vecs[v].errs});
            check($sformatf("v%0d_drop", v), drop_seen, {24'd0, vecs[v].drops});
        end

        // Latency: 4th byte at cycle N -> out_tvalid at N+2
        clear_mon();
        for (int i = 0; i < 4; i++) drive(8'hB0 + 8'(i), i == 0, i == 3, 16'd4);
        @(negedge clk);
        check("lat_n1_tvalid", {31'd0, out_tvalid}, 32'd0);
        @(negedge clk);
        check("lat_n2_tvalid", {31'd0, out_tvalid}, 32'd1);
        check("lat_n2_tdata", out_tdata, 32'hB0B1B2B3);
        #1; idle(4);

        // Backpressure: fill FIFO, reject next frame, then drain
        clear_mon();
        out_tready = 1'b0;
        for (int i = 0; i < 64; i++) drive(8'(i), i == 0, i == 63, 16'd64);
        idle(3);
        check("full_count", {27'd0, fifo_count}, 32'd16);
        for (int i = 0; i < 4; i++) drive(8'hE0 + 8'(i), i == 0, i == 3, 16'd4);
        idle(3);
        check("full_drop_pulse", drop_seen, 32'd1);
        check("full_no_err", err_seen, 32'd0);
        check("full_count_hold", {27'd0, fifo_count}, 32'd16);
        check("full_head_stable", out_tdata, 32'h00010203);
`ifdef RX_PACK_STATS_EN
        check("drop_cnt", {16'd0, drop_cnt}, drops_total);
`endif
        out_tready = 1'b1;
        for (int t = 0; t < 40 && q_data.size() < 16; t++) idle(1);
        idle(2);
        check("drain_nwords", q_data.size(), 32'd16);
        check("drain_first", q_data[0], 32'h00010203);
        check("drain_last_data", q_data[15], 32'h3C3D3E3F);
        check("drain_last_flag", {31'd0, q_last[15]}, 32'd1);
        check("drain_mid_flag", {31'd0, q_last[14]}, 32'd0);
        check("drain_count", {27'd0, fifo_count}, 32'd0);

        // tfirst inside PACK flushes the partial word, then a fresh frame
        clear_mon();
        drive(8'h01, 1'b1, 1'b0, 16'd8);
        drive(8'h02, 1'b0, 1'b0, 16'd8);
        drive(8'h03, 1'b0, 1'b0, 16'd8);
        drive(8'h44, 1'b1, 1'b0, 16'd4);
        drive(8'h55, 1'b0, 1'b1, 16'd4);
        for (int i = 0; i < 4; i++) drive(8'hC1 + 8'(i), i == 0, i == 3, 16'd4);
        idle(8);
        check("tf_nwords", q_data.size(), 32'd2);
        check("tf_flush_data", q_data[0], 32'h01020300);
        check("tf_flush_keep", {28'd0, q_keep[0]}, 32'hE);
        check("tf_flush_last", {31'd0, q_last[0]}, 32'd1);
        check("tf_next_data", q_data[1], 32'hC1C2C3C4);
        check("tf_len_err", err_seen, 32'd1);

        // Reset mid-frame with 3 words queued, stray bytes, then a clean frame
        clear_mon();
        out_tready = 1'b0;
        for (int i = 0; i < 13; i++) drive(8'h30 + 8'(i), i == 0, 1'b0, 16'd16);
        idle(2);
        check("mid_count", {27'd0, fifo_count}, 32'd3);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_count", {27'd0, fifo_count}, 32'd0);
        check("mid_rst_out", {out_tdata[31:1], out_tvalid}, 32'd0);
        check("mid_rst_keep", {27'd0, out_tkeep, out_tlast}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        out_tready = 1'b1;
        for (int i = 0; i < 3; i++) drive(8'h99, 1'b0, 1'b0, 16'd4);
        for (int i = 0; i < 4; i++) drive(8'hD1 + 8'(i), i == 0, i == 3, 16'd4);
        idle(8);
        check("post_nwords", q_data.size(), 32'd1);
        check("post_data", q_data[0], 32'hD1D2D3D4);
        check("post_keep_last", {27'd0, q_keep[0], q_last[0]}, {27'd0, 4'hF, 1'b1});
`ifdef RX_PACK_STATS_EN
        check("frame_cnt_after_rst", {16'd0, frame_cnt}, 32'd1);
`else
        check("stats_tied", {frame_cnt, drop_cnt}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
